// File: rtl/onchip_mem_width_adapter.sv
// Bridges a 32-bit request/response master onto a 64-bit single-port on-chip
// memory. Reads are pipelined through a three-stage pipeline, and out-of-range
// or conflicting requests are tallied in a saturating error counter.
module onchip_mem_width_adapter #(
  parameter int unsigned NUM_WORDS = 32000,
  parameter logic [31:0] OOB_DATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [3:0]  s_byteenable,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  input  logic        hold,
  output logic [14:0] m_address,
  output logic [7:0]  m_byteenable,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_clken,
  output logic [63:0] m_writedata,
  input  logic [63:0] m_readdata,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  input  logic        err_clr
);

  localparam int unsigned SAW     = 16;
  localparam int unsigned MAW     = 15;
  localparam int unsigned SDW     = 32;
  localparam int unsigned MDW     = 64;
  localparam int unsigned SBEW    = 4;
  localparam int unsigned MBEW    = 8;
  localparam int unsigned ECW     = 8;
  localparam logic [ECW-1:0] ECNT_MAX = '1;

  logic           accept_c;
  logic           oob_c;
  logic           rd_only_c;
  logic           err_c;
  logic [MAW-1:0] word_c;

  // Stage 1: memory command register plus read tag
  logic            cs_q;
  logic            wr_q;
  logic [MAW-1:0]  addr_q;
  logic [MBEW-1:0] be_q;
  logic [MDW-1:0]  wd_q;
  logic            s1_valid_q, s1_lane_q, s1_oob_q;
  // Stage 2: read tag aligned with the memory output
  logic            s2_valid_q, s2_lane_q, s2_oob_q;
  // Output register
  logic            rvalid_q;
  logic [SDW-1:0]  rdata_q, rdata_d;
  logic            sticky_q, sticky_d;
  logic [ECW-1:0]  cnt_q, cnt_d;

  assign word_c    = s_address[SAW-1:1];
  assign oob_c     = 32'(word_c) >= NUM_WORDS;
  assign accept_c  = (s_read | s_write) & ~hold;
  assign rd_only_c = s_read & ~s_write;
  assign err_c     = accept_c & (oob_c | (s_read & s_write));

  // Reset forces the upstream to stall and the memory to idle
  assign s_waitrequest = hold | ~reset_n;
  assign m_clken       = ~hold & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_lane_q  <= 1'b0;
      s1_oob_q   <= 1'b0;
    end else if (!hold) begin
      cs_q       <= accept_c & ~oob_c;
      s1_valid_q <= accept_c & rd_only_c;
      if (accept_c) begin
        wr_q      <= s_write;
        addr_q    <= word_c;
        be_q      <= s_address[0] ? {s_byteenable, SBEW'(0)} : {SBEW'(0), s_byteenable};
        wd_q      <= {s_writedata, s_writedata};
        s1_lane_q <= s_address[0];
        s1_oob_q  <= oob_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_lane_q  <= 1'b0;
      s2_oob_q   <= 1'b0;
    end else if (!hold) begin
      s2_valid_q <= s1_valid_q;
      s2_lane_q  <= s1_lane_q;
      s2_oob_q   <= s1_oob_q;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s2_valid_q) begin
      if (s2_oob_q)       rdata_d = OOB_DATA;
      else if (s2_lane_q) rdata_d = m_readdata[MDW-1:SDW];
      else                rdata_d = m_readdata[SDW-1:0];
    end
  end

  // A hold edge drops the strobe but keeps the last data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (hold) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= s2_valid_q;
      rdata_q  <= rdata_d;
    end
  end

  // Clear wins over accumulation, but an error in the clear cycle still registers
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (err_clr) begin
      sticky_d = err_c;
      cnt_d    = err_c ? ECW'(1) : '0;
    end else if (err_c) begin
      sticky_d = 1'b1;
      if (cnt_q != ECNT_MAX) cnt_d = cnt_q + ECW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_chipselect    = cs_q;
  assign m_write         = wr_q;
  assign m_address       = addr_q;
  assign m_byteenable    = be_q;
  assign m_writedata     = wd_q;
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;
  assign err_sticky      = sticky_q;
  assign err_count       = cnt_q;

endmodule

// File: tb/tb_onchip_mem_width_adapter.sv
// Bench for onchip_mem_width_adapter: a 64-bit memory model, a transaction-level
// reference (32-bit word store + read-latency queue) and directed scenarios.
module tb_onchip_mem_width_adapter;

  localparam int unsigned NUM_WORDS = 32000;
  localparam logic [31:0] OOB_DATA  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] s_address;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        hold;
  logic [14:0] m_address;
  logic [7:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken;
  logic [63:0] m_writedata;
  logic [63:0] m_readdata;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  onchip_mem_width_adapter #(.NUM_WORDS(NUM_WORDS), .OOB_DATA(OOB_DATA)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .hold(hold),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_clken(m_clken), .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .err_sticky(err_sticky), .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'hC0DE0000 + 32'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 64-bit single-port memory: registered address, unregistered output
  logic [63:0] mem [NUM_WORDS];
  logic [63:0] mem_q = '0;
  assign m_readdata = mem_q;

  initial for (int i = 0; i < int'(NUM_WORDS); i++) mem[i] = {pat(2*i+1), pat(2*i)};

  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write) begin
        for (int b = 0; b < 8; b++)
          if (m_byteenable[b]) mem[m_address][b*8 +: 8] <= m_writedata[b*8 +: 8];
      end else begin
        mem_q <= mem[m_address];
      end
    end
  end

  // Reference: 32-bit word store keyed by upstream address, reads complete after two live edges
  typedef struct { logic [31:0] data; int left; } rd_t;
  rd_t         pend[$];
  logic [31:0] ref_mem [int];
  logic        exp_rv = 1'b0, exp_cs = 1'b0, exp_wr = 1'b0, exp_sticky = 1'b0;
  logic [31:0] exp_rd = '0;
  logic [14:0] exp_addr = '0;
  logic [7:0]  exp_be = '0;
  logic [63:0] exp_wd = '0;
  int          exp_cnt = 0;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic acc, oobm, erri;
    logic [31:0] w;
    if (!reset_n) begin
      pend.delete();
      exp_rv = 0; exp_cs = 0; exp_cnt = 0; exp_sticky = 0;
    end else begin
      acc  = (s_read || s_write) && !hold;
      oobm = int'(s_address / 2) >= int'(NUM_WORDS);
      erri = acc && (oobm || (s_read && s_write));
      exp_rv = 0;
      if (!hold) begin
        foreach (pend[i]) pend[i].left--;
        if (pend.size() > 0 && pend[0].left == 0) begin
          exp_rv = 1;
          exp_rd = pend[0].data;
          void'(pend.pop_front());
        end
        exp_cs = acc && !oobm;
        if (acc) begin
          exp_wr   = s_write;
          exp_addr = 15'(s_address / 2);
          exp_be   = s_address[0] ? 8'(s_byteenable) << 4 : 8'(s_byteenable);
          exp_wd   = {s_writedata, s_writedata};
        end
        if (acc && s_read && !s_write)
          pend.push_back('{oobm ? OOB_DATA : ref_rd(int'(s_address)), 2});
        if (acc && s_write && !oobm) begin
          w = ref_rd(int'(s_address));
          for (int b = 0; b < 4; b++)
            if (s_byteenable[b]) w[b*8 +: 8] = s_writedata[b*8 +: 8];
          ref_mem[int'(s_address)] = w;
        end
      end
      if (err_clr) begin
        exp_sticky = erri;
        exp_cnt    = erri ? 1 : 0;
      end else if (erri) begin
        exp_sticky = 1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_waitrequest", 64'(s_waitrequest), 64'd1);
      chk("rst_clken", 64'(m_clken), 64'd0);
      chk("rst_rvalid", 64'(s_readdatavalid), 64'd0);
      chk("rst_cs", 64'(m_chipselect), 64'd0);
    end else begin
      chk("waitrequest", 64'(s_waitrequest), 64'(hold));
      chk("clken", 64'(m_clken), 64'(!hold));
      chk("rvalid", 64'(s_readdatavalid), 64'(exp_rv));
      if (exp_rv) chk("rdata", 64'(s_readdata), 64'(exp_rd));
      chk("chipselect", 64'(m_chipselect), 64'(exp_cs));
      if (exp_cs) begin
        chk("m_address", 64'(m_address), 64'(exp_addr));
        chk("m_byteenable", 64'(m_byteenable), 64'(exp_be));
        chk("m_writedata", m_writedata, exp_wd);
        chk("m_write", 64'(m_write), 64'(exp_wr));
      end
      chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
      chk("err_count", 64'(err_count), 64'(exp_cnt));
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    s_read = rd; s_write = wr; s_address = a; s_byteenable = be; s_writedata = wd;
    @(posedge clk); #1;
    s_read = 0; s_write = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int          got_n, first, last;
    logic [31:0] got [4];
    reset_n = 0; hold = 0; err_clr = 0;
    s_address = '0; s_read = 0; s_write = 0; s_byteenable = '0; s_writedata = '0;
    #1;
    chk("reset_wait", 64'(s_waitrequest), 64'd1);
    chk("reset_clken", 64'(m_clken), 64'd0);
    chk("reset_rdata", 64'(s_readdata), 64'd0);
    chk("reset_count", 64'(err_count), 64'd0);
    idle(2);
    reset_n = 1;
    idle(1);

    // Write into the upper lane of word 1
    req(0, 1, 16'h0003, 4'hF, 32'h12345678);
    chk("wr_addr", 64'(m_address), 64'h0001);
    chk("wr_be", 64'(m_byteenable), 64'hF0);
    chk("wr_data", m_writedata, 64'h1234567812345678);
    chk("wr_cs", 64'(m_chipselect), 64'd1);
    chk("wr_write", 64'(m_write), 64'd1);

    // Read latency: strobe only in the cycle after accept edge + 2
    req(1, 0, 16'h0003, 4'hF, 0);
    chk("lat_k", 64'(s_readdatavalid), 64'd0);
    idle(1);
    chk("lat_k1", 64'(s_readdatavalid), 64'd0);
    idle(1);
    chk("lat_k2_valid", 64'(s_readdatavalid), 64'd1);
    chk("lat_k2_data", 64'(s_readdata), 64'h12345678);
    idle(1);
    chk("lat_k3", 64'(s_readdatavalid), 64'd0);

    // Four back-to-back reads
    got_n = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      s_read = (i < 4); s_address = 16'(i); s_byteenable = 4'hF;
      @(posedge clk); #1;
      s_read = 0;
      if (s_readdatavalid) begin
        if (got_n < 4) got[got_n] = s_readdata;
        if (first < 0) first = i;
        last = i;
        got_n++;
      end
    end
    chk("b2b_count", 64'(got_n), 64'd4);
    chk("b2b_first", 64'(first), 64'd2);
    chk("b2b_last", 64'(last), 64'd5);
    chk("b2b_d0", 64'(got[0]), 64'hC0DE0000);
    chk("b2b_d1", 64'(got[1]), 64'hC0DE0001);
    chk("b2b_d2", 64'(got[2]), 64'hC0DE0002);
    chk("b2b_d3", 64'(got[3]), 64'h12345678);

    // Partial byte-enable writes on both lanes
    req(0, 1, 16'h0004, 4'b0101, 32'hAABBCCDD);
    req(0, 1, 16'h0005, 4'b1000, 32'h11223344);
    chk("pbe_hi", 64'(m_byteenable), 64'h80);
    req(1, 0, 16'h0004, 4'hF, 0);
    req(1, 0, 16'h0005, 4'hF, 0);
    idle(1);
    chk("pbe_lo_data", 64'(s_readdata), 64'hC0BB00DD);
    idle(1);
    chk("pbe_hi_data", 64'(s_readdata), 64'h11DE0005);

    // Out-of-range read at the first invalid word
    req(1, 0, 16'hFA00, 4'hF, 0);
    chk("oob_rd_cs", 64'(m_chipselect), 64'd0);
    chk("oob_rd_cnt", 64'(err_count), 64'd1);
    chk("oob_rd_sticky", 64'(err_sticky), 64'd1);
    idle(2);
    chk("oob_rd_valid", 64'(s_readdatavalid), 64'd1);
    chk("oob_rd_data", 64'(s_readdata), 64'hDEADBEEF);

    // Last valid word is accepted, first invalid write is dropped
    req(0, 1, 16'hF9FF, 4'hF, 32'h0BADF00D);
    chk("last_cs", 64'(m_chipselect), 64'd1);
    chk("last_addr", 64'(m_address), 64'h7CFF);
    req(0, 1, 16'hFA02, 4'hF, 32'h01020304);
    chk("oob_wr_cs", 64'(m_chipselect), 64'd0);
    chk("oob_wr_cnt", 64'(err_count), 64'd2);
    req(1, 0, 16'hF9FF, 4'hF, 0);
    idle(2);
    chk("last_data", 64'(s_readdata), 64'h0BADF00D);

    // Simultaneous read and write acts as a write
    req(1, 1, 16'h0010, 4'hF, 32'h55AA55AA);
    chk("rw_write", 64'(m_write), 64'd1);
    chk("rw_cnt", 64'(err_count), 64'd3);
    idle(3);
    req(1, 0, 16'h0010, 4'hF, 0);
    idle(2);
    chk("rw_data", 64'(s_readdata), 64'h55AA55AA);

    // Hold for three edges with two reads in flight
    req(1, 0, 16'h0000, 4'hF, 0);
    req(1, 0, 16'h0001, 4'hF, 0);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("hold_valid", 64'(s_readdatavalid), 64'd0);
      chk("hold_wait", 64'(s_waitrequest), 64'd1);
      chk("hold_clken", 64'(m_clken), 64'd0);
    end
    hold = 0;
    got_n = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (s_readdatavalid) begin
        if (got_n < 2) got[got_n] = s_readdata;
        if (got_n == 0) chk("hold_first_pos", 64'(i), 64'd0);
        got_n++;
      end
    end
    chk("hold_count", 64'(got_n), 64'd2);
    chk("hold_d0", 64'(got[0]), 64'hC0DE0000);
    chk("hold_d1", 64'(got[1]), 64'hC0DE0001);

    // Error clear alone, then clear coinciding with an error
    err_clr = 1;
    idle(1);
    chk("clr_cnt", 64'(err_count), 64'd0);
    chk("clr_sticky", 64'(err_sticky), 64'd0);
    req(1, 0, 16'hFA00, 4'hF, 0);
    err_clr = 0;
    chk("clr_err_cnt", 64'(err_count), 64'd1);
    chk("clr_err_sticky", 64'(err_sticky), 64'd1);
    idle(3);

    // Asynchronous reset with a read in flight
    req(1, 0, 16'h0002, 4'hF, 0);
    idle(1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_valid", 64'(s_readdatavalid), 64'd0);
    chk("mid_rst_data", 64'(s_readdata), 64'd0);
    chk("mid_rst_cs", 64'(m_chipselect), 64'd0);
    chk("mid_rst_addr", 64'(m_address), 64'd0);
    chk("mid_rst_cnt", 64'(err_count), 64'd0);
    chk("mid_rst_wait", 64'(s_waitrequest), 64'd1);
    @(posedge clk); #1;
    reset_n = 1;
    got_n = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (s_readdatavalid) got_n++;
    end
    chk("mid_rst_nostrobe", 64'(got_n), 64'd0);

    // Saturation after 256 errors
    for (int i = 0; i < 256; i++) req(1, 0, 16'hFA00, 4'hF, 0);
    idle(3);
    chk("sat_cnt", 64'(err_count), 64'd255);
    chk("sat_sticky", 64'(err_sticky), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_width_adapter.md
ONCHIP_MEM_WIDTH_ADAPTER -- requirements
Module: onchip_mem_width_adapter

Interface
REQ-001 Parameter: NUM_WORDS, 32000, number of valid 64-bit memory words.
REQ-002 Parameter: OOB_DATA, 32'hDEADBEEF, read data returned for out-of-range reads.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 s_address  in  16  32-bit word address from the upstream master.
REQ-006 s_read / s_write  in  1 each  upstream read and write requests.
REQ-007 s_byteenable  in  4  upstream byte lanes; s_writedata  in  32  write data.
REQ-008 s_waitrequest  out  1  high = request not accepted this cycle.
REQ-009 s_readdata  out  32  read data; s_readdatavalid  out  1  one-cycle read-data strobe.
REQ-010 hold  in  1  freeze request; stalls the whole pipeline, including the memory clock enable.
REQ-011 m_address  out  15; m_byteenable  out  8; m_chipselect, m_write, m_clken  out  1 each; m_writedata  out  64. These drive the 64-bit single-port on-chip memory.
REQ-012 m_readdata  in  64  unregistered memory output, valid the cycle after the address edge.
REQ-013 err_sticky  out  1; err_count  out  8; err_clr  in  1.

Function
REQ-014 Acceptance: a request is accepted on an edge where (s_read|s_write)=1, s_waitrequest=0 and hold=0. s_waitrequest equals hold.
REQ-015 Stage 1 (command register), loaded on accept: m_address=s_address[15:1]; m_byteenable={s_byteenable,4'h0} if s_address[0]=1, else {4'h0,s_byteenable}; m_writedata={s_writedata,s_writedata}; m_write=s_write.
REQ-016 m_chipselect is high for exactly one non-hold cycle per accepted in-range request; it is low otherwise.
REQ-017 m_clken equals ~hold.
REQ-018 Out of range: s_address[15:1] >= NUM_WORDS. An out-of-range write is dropped (m_chipselect stays 0). An out-of-range read never touches memory and returns OOB_DATA. Both cases count as errors.
REQ-019 Simultaneous s_read and s_write: treated as a write; the read is dropped and counted as an error.
REQ-020 Read pipeline: stage 1 (valid, lane, oob) moves to stage 2 on the next non-hold edge. Stage 2 moves to the output register on the following non-hold edge. At that move, s_readdata = oob ? OOB_DATA : lane ? m_readdata[63:32] : m_readdata[31:0].
REQ-021 Read latency: with hold=0, a read accepted at edge k gives s_readdatavalid=1 for exactly the cycle after edge k+2. Back-to-back reads give one strobe per cycle, in order.
REQ-022 Hold behaviour: every edge with hold=1 clears s_readdatavalid, keeps s_readdata, and freezes stages 1 and 2. Each read produces exactly one strobe, with no loss or duplication.
REQ-023 Writes produce no s_readdatavalid.
REQ-024 Errors: each error sets err_sticky and increments err_count, which saturates at 255.
REQ-025 err_clr=1 clears both err_sticky and err_count. If an error occurs in the same cycle as err_clr, the result is err_sticky=1 and err_count=1.

Reset
REQ-026 With reset_n=0 (asynchronous): stage valids cleared; s_readdatavalid=0; s_readdata=0; m_chipselect=0; m_write=0; m_address=0; m_byteenable=0; m_writedata=0; err_sticky=0; err_count=0.
REQ-027 While reset_n=0: s_waitrequest=1 and m_clken=0, regardless of hold.
REQ-028 Reset during in-flight reads discards them; no s_readdatavalid is issued for them after release.

Verification
REQ-029 Write s_address=16'h0003, be=4'hF, data=32'h12345678 -> next cycle m_address=15'h0001, m_byteenable=8'hF0, m_writedata=64'h1234567812345678, m_chipselect=1, m_write=1.
REQ-030 Write then read at 16'h0003 with hold=0 -> s_readdatavalid pulses in the cycle after accept edge+2 with s_readdata=32'h12345678.
REQ-031 Four back-to-back reads at 0,1,2,3 -> four consecutive strobes with data in order.
REQ-032 Read at 16'hFA00 (word 32000) -> m_chipselect stays 0; s_readdata=32'hDEADBEEF; err_sticky=1; err_count=1.
REQ-033 hold=1 for 3 cycles while two reads are in flight -> s_waitrequest=1, m_clken=0, no strobes during hold; exactly two strobes with correct data after release.
REQ-034 reset_n asserted mid-read -> outputs at reset values immediately; no strobe after release; 256 errors -> err_count=255.
